ff_fifo_drain_scheduler: RTL and testbench

//  Drains N show-ahead FIFOs (ff_fifo_pow2_depth style: read_data valid while !empty) into one

---
 rtl/ff_fifo_sched_pkg.sv | 11 +
 rtl/ff_fifo_drain_scheduler_pick.sv | 37 +++
 rtl/ff_fifo_drain_scheduler.sv | 124 ++++++++++++
 tb/tb_ff_fifo_drain_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_fifo_sched_pkg.sv
// Shared helpers for the FIFO drain scheduler.
// Index widths are never allowed to collapse to zero bits, so every
// queue index signal can be declared as [w-1:0] safely.
package ff_fifo_sched_pkg;

    // max(1, $clog2(n)): width of an index into n items
    function automatic int rr_clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ff_fifo_drain_scheduler_pick.sv
// Round-robin search: first set request at or after a start index,
// wrapping modulo n. Works for non-power-of-two n; start must be < n.
module rr_pick_next
    import ff_fifo_sched_pkg::*;
#(
    parameter  int n  = 4,
    localparam int iw = rr_clog2_min1(n)
) (
    input  logic [n-1:0]  req,
    input  logic [iw-1:0] start,
    output logic          found,
    output logic [iw-1:0] idx
);

    localparam logic [iw:0] n_w = (iw + 1)'(n);

    // One extra bit so start + k never overflows before the modulo fold.
    logic [iw:0] sum;

    // Scan offsets from far to near so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = n - 1; k >= 0; k--) begin
            sum = {1'b0, start} + k[iw:0];
            if (sum >= n_w) begin
                sum = sum - n_w;
            end
            if (req[sum[iw-1:0]]) begin
                found = 1'b1;
                idx   = sum[iw-1:0];
            end
        end
    end

endmodule

// File: rtl/ff_fifo_drain_scheduler.sv
// Drains a bank of show-ahead FIFOs into one registered valid/ready stream.
// Round-robin between enabled, non-empty queues; the current queue keeps the
// grant for at most max_burst consecutive pops while another queue waits.
//
// Handshake: a word transfers on a cycle where out_valid & out_ready. While
// out_valid & !out_ready, out_valid/out_data/out_src are held unchanged and no
// FIFO is popped. A new word can be loaded in the same cycle the held word is
// accepted, giving one word per cycle under continuous out_ready.
module ff_fifo_drain_scheduler
    import ff_fifo_sched_pkg::*;
#(
    parameter  int n_queues  = 4,
    parameter  int width     = 64,
    parameter  int max_burst = 4,
    localparam int qw        = rr_clog2_min1(n_queues),
    localparam int bw        = $clog2(max_burst + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_queues-1:0]       q_empty,
    input  logic [n_queues*width-1:0] q_data,
    output logic [n_queues-1:0]       q_pop,
    input  logic [n_queues-1:0]       queue_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [width-1:0]          out_data,
    output logic [qw-1:0]             out_src
);

    localparam logic [qw-1:0] last_q    = qw'(n_queues - 1);
    localparam logic [bw-1:0] burst_lim = bw'(max_burst);
    localparam logic [bw-1:0] burst_one = bw'(1);

    logic [n_queues-1:0] eligible;
    logic                slot_free;
    logic                do_pop;
    logic [qw-1:0]       cur;
    logic [bw-1:0]       burst_cnt;
    logic [qw-1:0]       next_start;
    logic                pick_found;
    logic [qw-1:0]       pick_idx;
    logic [qw-1:0]       grant;
    logic [width-1:0]    grant_data;

    assign eligible  = queue_en & ~q_empty;
    assign slot_free = !out_valid || out_ready;

    // Search starts just past the current queue and wraps back to it.
    always_comb begin
        next_start = (cur == last_q) ? '0 : cur + 1'b1;
    end

    rr_pick_next #(
        .n(n_queues)
    ) u_pick (
        .req  (eligible),
        .start(next_start),
        .found(pick_found),
        .idx  (pick_idx)
    );

    // Keep the current queue while it has burst budget, else rotate.
    always_comb begin
        if (eligible[cur] && (burst_cnt < burst_lim)) begin
            grant = cur;
        end else begin
            grant = pick_idx;
        end
    end

    // The search covers every queue, so pick_found is "any queue eligible".
    // Held low during reset so no FIFO loses a word while we are cleared.
    assign do_pop = pick_found && slot_free && !rst;

    // One-hot pop strobe toward the granted FIFO.
    always_comb begin
        q_pop = '0;
        if (do_pop) begin
            q_pop[grant] = 1'b1;
        end
    end

    // Select the granted FIFO's head word.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < n_queues; i++) begin
            if (grant == qw'(i)) begin
                grant_data = q_data[i*width +: width];
            end
        end
    end

    // Output register: load on pop, drop valid once the word is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (do_pop) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Burst tracking: count pops from cur; a re-grant of cur with the budget
    // spent (only possible when it is the sole eligible queue) restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= '0;
            burst_cnt <= '0;
        end else if (do_pop) begin
            if (grant == cur) begin
                burst_cnt <= (burst_cnt < burst_lim) ? burst_cnt + 1'b1 : burst_one;
            end else begin
                cur       <= grant;
                burst_cnt <= burst_one;
            end
        end
    end

endmodule

// File: tb/tb_ff_fifo_drain_scheduler.sv
// Bench for ff_fifo_drain_scheduler: FIFO bank model, scoreboards, scenario tasks.
module tb_ff_fifo_drain_scheduler;

    localparam int NQ    = 4;
    localparam int W     = 8;
    localparam int MB    = 2;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NQ-1:0]   q_empty;
    logic [NQ*W-1:0] q_data;
    logic [NQ-1:0]   q_pop;
    logic [NQ-1:0]   queue_en;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [1:0]      out_src;

    ff_fifo_drain_scheduler #(
        .n_queues (NQ),
        .width    (W),
        .max_burst(MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .q_empty  (q_empty),
        .q_data   (q_data),
        .q_pop    (q_pop),
        .queue_en (queue_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src)
    );

    // ---------------- models and scoreboards ----------------
    int total = 0;
    int bad   = 0;

    logic [W-1:0]   fifo_m[NQ][$];
    logic [W-1:0]   exp_pq[NQ][$];
    logic [W+1:0]   exp_q[$];
    logic [5:0]     seq_ctr[NQ];
    logic           seq_mode;
    logic           burst_chk;
    int             run_cnt;
    int             run_src;

    logic [NQ-1:0]  s_pop;
    logic           s_ov;
    logic [W-1:0]   s_od;
    logic [1:0]     s_os;

    // ---------------- driver tasks ----------------
    task automatic drive_fifo();
        for (int i = 0; i < NQ; i++) begin
            q_empty[i] = (fifo_m[i].size() == 0);
            q_data[i*W +: W] = (fifo_m[i].size() == 0) ? '0 : fifo_m[i][0];
        end
    endtask

    task automatic push_word(input int q, input logic [W-1:0] d);
        fifo_m[q].push_back(d);
        exp_pq[q].push_back(d);
        drive_fifo();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        queue_en  = '1;
        for (int i = 0; i < NQ; i++) begin
            fifo_m[i].delete();
            exp_pq[i].delete();
            seq_ctr[i] = '0;
        end
        exp_q.delete();
        run_cnt = 0;
        run_src = 0;
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: sample and check at negedge, apply pops to the model after posedge.
    task automatic cycle();
        logic [NQ-1:0] elig;
        logic [NQ-1:0] others;
        logic          slot;
        logic [W+1:0]  e;
        logic [W-1:0]  ed;
        int            g;
        @(negedge clk);
        s_pop = q_pop;
        s_ov  = out_valid;
        s_od  = out_data;
        s_os  = out_src;
        elig  = queue_en & ~q_empty;
        slot  = !s_ov || out_ready;
        if (!rst) begin
            total++;
            if ($countones(s_pop) > 1 || (s_pop & ~elig) != 0) begin
                bad++;
                $display("FAIL pop_legal: q_pop=%b eligible=%b", s_pop, elig);
            end
            total++;
            if (!slot && s_pop != 0) begin
                bad++;
                $display("FAIL pop_stall: q_pop=%b while output stalled, want 0000", s_pop);
            end
            total++;
            if (slot && elig != 0 && s_pop == 0) begin
                bad++;
                $display("FAIL pop_missing: q_pop=0000 with eligible=%b and free slot", elig);
            end
            if (s_ov && out_ready) begin
                total++;
                if (seq_mode) begin
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL out_extra: got src=%0d data=%h, want nothing", s_os, s_od);
                    end else begin
                        e = exp_q.pop_front();
                        if ({s_os, s_od} !== e) begin
                            bad++;
                            $display("FAIL out_seq: got src=%0d data=%h, want src=%0d data=%h",
                                     s_os, s_od, e[W+1:W], e[W-1:0]);
                        end
                    end
                end else begin
                    if (exp_pq[int'(s_os)].size() == 0) begin
                        bad++;
                        $display("FAIL out_extra: got src=%0d data=%h, queue had nothing", s_os, s_od);
                    end else begin
                        ed = exp_pq[int'(s_os)].pop_front();
                        if (s_od !== ed) begin
                            bad++;
                            $display("FAIL out_order: src=%0d got data=%h, want %h", s_os, s_od, ed);
                        end
                    end
                end
            end
            if (burst_chk && s_pop != 0) begin
                g = 0;
                for (int i = 0; i < NQ; i++) if (s_pop[i]) g = i;
                others = elig & ~(NQ'(1) << g);
                if (others == 0) begin
                    run_cnt = 0;
                    run_src = g;
                end else begin
                    if (g == run_src) run_cnt++;
                    else begin
                        run_cnt = 1;
                        run_src = g;
                    end
                    total++;
                    if (run_cnt > MB) begin
                        bad++;
                        $display("FAIL burst_run: queue %0d run=%0d while others=%b, want <= %0d",
                                 g, run_cnt, others, MB);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (s_pop[i] && fifo_m[i].size() > 0) void'(fifo_m[i].pop_front());
        end
        drive_fifo();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        queue_en  = '1;
        for (int i = 0; i < NQ; i++)
            for (int k = 0; k < 2; k++) push_word(i, 8'(i * 16 + k + 1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (q_pop !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
                bad++;
                $display("FAIL reset_hold: pop=%b valid=%b data=%h src=%0d, want all 0",
                         q_pop, out_valid, out_data, out_src);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        cycle();
        total++;
        if (s_ov !== 1'b1 || s_od !== 8'h01 || s_os !== 2'd0) begin
            bad++;
            $display("FAIL reset_release: valid=%b data=%h src=%0d, want 1 01 0", s_ov, s_od, s_os);
        end
        rst = 1'b1;
        #1;
        total++;
        if (q_pop !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
            bad++;
            $display("FAIL reset_async: pop=%b valid=%b data=%h src=%0d, want all 0",
                     q_pop, out_valid, out_data, out_src);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (q_pop !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
                bad++;
                $display("FAIL reset_hold: pop=%b valid=%b data=%h src=%0d, want all 0",
                         q_pop, out_valid, out_data, out_src);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        seq_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_word(2, 8'(8'h10 + k));
            exp_q.push_back({2'd2, 8'(8'h10 + k)});
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k >= 1 && k <= 4) begin
                total++;
                if (s_ov !== 1'b1) begin
                    bad++;
                    $display("FAIL single_stream: cycle %0d valid=%b, want 1", k, s_ov);
                end
            end
        end
        total++;
        if (s_ov !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL single_end: valid=%b left=%0d, want 0 0", s_ov, exp_q.size());
        end
    endtask

    task automatic test_burst();
        do_reset();
        seq_mode = 1'b1;
        push_word(0, 8'hA0); push_word(0, 8'hA1); push_word(0, 8'hA2);
        push_word(1, 8'hB0); push_word(1, 8'hB1);
        push_word(3, 8'hD0);
        exp_q.push_back({2'd0, 8'hA0});
        exp_q.push_back({2'd0, 8'hA1});
        exp_q.push_back({2'd1, 8'hB0});
        exp_q.push_back({2'd1, 8'hB1});
        exp_q.push_back({2'd3, 8'hD0});
        exp_q.push_back({2'd0, 8'hA2});
        out_ready = 1'b1;
        repeat (8) cycle();
        total++;
        if (s_ov !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL burst_end: valid=%b left=%0d, want 0 0", s_ov, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        seq_mode = 1'b1;
        push_word(1, 8'h05);
        push_word(1, 8'h06);
        exp_q.push_back({2'd1, 8'h05});
        exp_q.push_back({2'd1, 8'h06});
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++;
            if (s_ov !== 1'b1 || s_od !== 8'h05 || s_os !== 2'd1 || s_pop !== '0) begin
                bad++;
                $display("FAIL stall_hold: valid=%b data=%h src=%0d pop=%b, want 1 05 1 0000",
                         s_ov, s_od, s_os, s_pop);
            end
        end
        out_ready = 1'b1;
        repeat (3) cycle();
        total++;
        if (s_ov !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_end: valid=%b left=%0d, want 0 0", s_ov, exp_q.size());
        end
    endtask

    task automatic test_mask();
        int  nwords;
        logic seen;
        do_reset();
        seq_mode  = 1'b0;
        burst_chk = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            push_word(0, 8'(k));
            push_word(1, 8'(8'h10 + k));
        end
        queue_en  = 4'b0001;
        out_ready = 1'b1;
        repeat (6) begin
            cycle();
            if (s_ov) begin
                total++;
                if (s_os !== 2'd0) begin
                    bad++;
                    $display("FAIL mask_src: got src=%0d while masked, want 0", s_os);
                end
            end
        end
        queue_en = 4'b0011;
        nwords   = 0;
        seen     = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            cycle();
            if (s_ov) begin
                nwords++;
                if (s_os == 2'd1) seen = 1'b1;
            end
        end
        total++;
        if (!seen || nwords > 3) begin
            bad++;
            $display("FAIL mask_enable: src1 seen=%b after %0d words, want seen within 3", seen, nwords);
        end
    endtask

    task automatic test_random();
        logic done;
        int   left;
        do_reset();
        seq_mode  = 1'b0;
        burst_chk = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NQ; i++) begin
                if (fifo_m[i].size() < DEPTH && $urandom_range(0, 99) < 30) begin
                    push_word(i, {2'(i), seq_ctr[i]});
                    seq_ctr[i] = seq_ctr[i] + 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end
        out_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            cycle();
            left = 0;
            for (int i = 0; i < NQ; i++) left += fifo_m[i].size();
            done = (left == 0) && !s_ov && (s_pop == '0);
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: stream still busy after 100 cycles, want idle");
        end
        left = 0;
        for (int i = 0; i < NQ; i++) left += exp_pq[i].size();
        total++;
        if (left != 0) begin
            bad++;
            $display("FAIL random_lost: %0d words never delivered, want 0", left);
        end
        burst_chk = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        queue_en  = '1;
        q_empty   = '1;
        q_data    = '0;
        seq_mode  = 1'b1;
        burst_chk = 1'b0;
        run_cnt   = 0;
        run_src   = 0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_mask();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "time limit");
    end

endmodule
